// File: rtl/adder_share_arb.sv
// ============================================================================
//  Module      : adder_share_arb
//  Description : Two-slot arbiter sharing one 32-bit adder, with a registered
//                single-entry result stage and a saturating conflict counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Result width matches the operands, so the carry-out is dropped (mod 2^32).
  assign sum = a + b;
endmodule

module adder_share_arb #(
  parameter int TAG_W     = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic [15:0]      conflict_cnt
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic             r_out_valid;
  logic [31:0]      r_out_q;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_src;
  logic             r_last_grant;
  logic [15:0]      r_conflict_cnt;

  logic             w_can_accept;
  logic             w_both;
  logic             w_grant;
  logic             w_xfer;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [31:0]      w_sum;
  logic [TAG_W-1:0] w_tag;

  assign w_can_accept = !r_out_valid | out_ready;
  assign w_both       = req0_valid & req1_valid;

  // On a tie, round-robin hands the grant to the slot that did not win last.
  assign w_grant = w_both ? ((PRIO_MODE == 1) ? 1'b0 : ~r_last_grant) : req1_valid;

  assign req0_ready = !rst & w_can_accept & req0_valid & !w_grant;
  assign req1_ready = !rst & w_can_accept & req1_valid &  w_grant;
  assign w_xfer     = req0_ready | req1_ready;

  assign w_a   = w_grant ? req1_a   : req0_a;
  assign w_b   = w_grant ? req1_b   : req0_b;
  assign w_tag = w_grant ? req1_tag : req0_tag;

  adder_32 u_adder (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_q        <= '0;
      r_out_tag      <= '0;
      r_out_src      <= 1'b0;
      r_last_grant   <= 1'b1;
      r_conflict_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid  <= 1'b1;
        r_out_q      <= w_sum;
        r_out_tag    <= w_tag;
        r_out_src    <= w_grant;
        r_last_grant <= w_grant;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
      // Stalled ties are not conflicts; only refusals caused by arbitration count.
      if (w_both && w_can_accept && r_conflict_cnt != c_cnt_max)
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_q        = r_out_q;
  assign out_tag      = r_out_tag;
  assign out_src      = r_out_src;
  assign conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arb.sv
// ============================================================================
//  Module      : tb_adder_share_arb
//  Description : Bench driving a round-robin and a fixed-priority instance
//                with shared stimulus, checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arb;

  logic        clk, rst, v0, v1, ordy;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  t0, t1;

  logic [1:0]        rdy0_o, rdy1_o, ov_o, src_o;
  logic [1:0][31:0]  q_o;
  logic [1:0][4:0]   tag_o;
  logic [1:0][15:0]  cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
  bit          m_v[2];
  logic [31:0] m_q[2];
  logic [4:0]  m_t[2];
  bit          m_s[2];
  bit          m_last[2];
  int          m_cnt[2];

  adder_share_arb #(.TAG_W(5), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_tag(t0), .req0_ready(rdy0_o[0]),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_tag(t1), .req1_ready(rdy1_o[0]),
    .out_valid(ov_o[0]), .out_ready(ordy), .out_q(q_o[0]), .out_tag(tag_o[0]),
    .out_src(src_o[0]), .conflict_cnt(cnt_o[0])
  );

  adder_share_arb #(.TAG_W(5), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_tag(t0), .req0_ready(rdy0_o[1]),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_tag(t1), .req1_ready(rdy1_o[1]),
    .out_valid(ov_o[1]), .out_ready(ordy), .out_q(q_o[1]), .out_tag(tag_o[1]),
    .out_src(src_o[1]), .conflict_cnt(cnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, m, obs, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 0; m_q[m] = '0; m_t[m] = '0; m_s[m] = 0; m_last[m] = 1; m_cnt[m] = 0;
    end
  endtask

  task automatic chk_outputs();
    for (int m = 0; m < 2; m++) begin
      chk("out_valid", m, 32'(ov_o[m]), 32'(m_v[m]));
      chk("out_q", m, q_o[m], m_q[m]);
      chk("out_tag", m, 32'(tag_o[m]), 32'(m_t[m]));
      chk("out_src", m, 32'(src_o[m]), 32'(m_s[m]));
      chk("conflict_cnt", m, 32'(cnt_o[m]), 32'(m_cnt[m]));
    end
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic step(input bit en);
    bit acc0[2], acc1[2], can[2];
    #1;
    for (int m = 0; m < 2; m++) begin
      bit win1;
      can[m] = !m_v[m] || ordy;
      if (v0 && v1) win1 = (m == 1) ? 1'b0 : !m_last[m];
      else          win1 = v1;
      acc0[m] = can[m] && v0 && !win1;
      acc1[m] = can[m] && v1 && win1;
      if (en) begin
        chk("req0_ready", m, 32'(rdy0_o[m]), 32'(acc0[m]));
        chk("req1_ready", m, 32'(rdy1_o[m]), 32'(acc1[m]));
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (v0 && v1 && can[m] && m_cnt[m] < 65535) m_cnt[m]++;
      if (acc0[m] || acc1[m]) begin
        m_v[m]    = 1;
        m_q[m]    = acc1[m] ? a1 + b1 : a0 + b0;
        m_t[m]    = acc1[m] ? t1 : t0;
        m_s[m]    = acc1[m];
        m_last[m] = acc1[m];
      end else if (ordy) begin
        m_v[m] = 0;
      end
    end
    #1;
    if (en) chk_outputs();
  endtask

  task automatic rand_ops();
    a0 = $urandom; b0 = $urandom; t0 = 5'($urandom);
    a1 = $urandom; b1 = $urandom; t1 = 5'($urandom);
  endtask

  initial begin
    rst = 1'b1; v0 = 1; v1 = 1; ordy = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; t0 = 0; t1 = 0;
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      chk("rst_rdy0", m, 32'(rdy0_o[m]), 32'd0);
      chk("rst_rdy1", m, 32'(rdy1_o[m]), 32'd0);
    end
    chk_outputs();
    rst = 1'b0; v0 = 0; v1 = 0;

    // Single add from slot 0
    v0 = 1; a0 = 32'd1209; b0 = 32'd4565; t0 = 5'd3; ordy = 1;
    step(1);
    chk("t1_q", 0, q_o[0], 32'd5774);
    chk("t1_tag", 0, 32'(tag_o[0]), 32'd3);
    chk("t1_src", 0, 32'(src_o[0]), 32'd0);

    // Overflow wrap from slot 1
    v0 = 0; v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'd1; t1 = 5'd9;
    step(1);
    chk("t2_q", 0, q_o[0], 32'd0);
    chk("t2_src", 0, 32'(src_o[0]), 32'd1);

    // Both valid: alternate on round-robin, slot 0 always on fixed priority
    v0 = 1; v1 = 1;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      step(1);
      chk("t3_src_rr", 0, 32'(src_o[0]), 32'(i % 2));
      chk("t3_src_fp", 1, 32'(src_o[1]), 32'd0);
    end
    chk("t3_cnt", 0, 32'(cnt_o[0]), 32'd4);

    // Backpressure: stalled output holds, no conflicts counted
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step(1);
    end
    chk("t4_cnt_held", 0, 32'(cnt_o[0]), 32'd4);
    ordy = 1;
    step(1);
    chk("t4_drain_accept_valid", 0, 32'(ov_o[0]), 32'd1);
    chk("t4_drain_accept_src", 0, 32'(src_o[0]), 32'd0);

    // Fixed priority keeps slot 0
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step(1);
      chk("t5_src_fp", 1, 32'(src_o[1]), 32'd0);
    end

    // Randomized traffic with an asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); ordy = ($urandom_range(0, 3) != 0);
      rand_ops();
      if (i == 200) begin
        rst = 1'b1;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
          chk("midrst_valid", m, 32'(ov_o[m]), 32'd0);
          chk("midrst_cnt", m, 32'(cnt_o[m]), 32'd0);
          chk("midrst_rdy0", m, 32'(rdy0_o[m]), 32'd0);
          chk("midrst_rdy1", m, 32'(rdy1_o[m]), 32'd0);
        end
        #2 rst = 1'b0;
      end
      step(1);
    end

    // Saturation of the conflict counter
    v0 = 1; v1 = 1; ordy = 1;
    for (int i = 0; i < 70000; i++) step(0);
    step(1);
    chk("sat_cnt_rr", 0, 32'(cnt_o[0]), 32'hFFFF);
    chk("sat_cnt_fp", 1, 32'(cnt_o[1]), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
